// File: rtl/seq_exec_unit.sv
// seq_exec_unit: multi-cycle MUL/SLL/SRA/ROR execution unit with register-file writeback.
// One iteration per clock; the result and write address are presented for a single DONE cycle.
module seq_exec_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OPCODE,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       DESTIN,
    output logic [WIDTH-1:0] RESULT,
    output logic             WRITE,
    output logic [2:0]       WRADDR,
    output logic             BUSY,
    output logic             DONE
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
    logic [WIDTH-1:0] acc_nx;
    logic [1:0]       op_q, op_d;
    logic [2:0]       dest_q, dest_d, wraddr_q, wraddr_d;
    logic [CW-1:0]    cnt_q, cnt_d, len;

    assign len = (OPCODE == 2'b00) ? CW'(WIDTH) : CW'(DATA2[SW-1:0]);

    always_comb begin
        acc_nx = (op_q == 2'b00) ? (mplier_q[0] ? acc_q + mcand_q : acc_q) :
                 (op_q == 2'b01) ? {acc_q[WIDTH-2:0], 1'b0} :
                 (op_q == 2'b10) ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} :
                                   {acc_q[0], acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        op_d     = op_q;
        dest_d   = dest_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        wraddr_d = wraddr_q;
        case (state_q)
            S_IDLE: if (START) begin
                op_d     = OPCODE;
                dest_d   = DESTIN;
                mcand_d  = DATA1;
                mplier_d = DATA2;
                acc_d    = (OPCODE == 2'b00) ? '0 : DATA1;
                cnt_d    = len;
                state_d  = (len == '0) ? S_DONE : S_RUN;
                // a zero-length shift completes on the accept edge with the operand untouched
                if (len == '0) begin
                    result_d = DATA1;
                    wraddr_d = DESTIN;
                end
            end
            S_RUN: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = acc_nx;
                    wraddr_d = dest_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            op_q     <= '0;
            dest_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            wraddr_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            wraddr_q <= wraddr_d;
        end
    end

    assign RESULT = result_q;
    assign WRADDR = wraddr_q;
    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = (state_q == S_DONE);
    assign WRITE  = (state_q == S_DONE);
endmodule

// File: tb/tb_seq_exec_unit.sv
// tb_seq_exec_unit: timeline/arithmetic reference model plus directed literal checks for seq_exec_unit.
module tb_seq_exec_unit;
    logic       CLK, RESET, START;
    logic [1:0] OPCODE;
    logic [7:0] DATA1, DATA2;
    logic [2:0] DESTIN;
    logic [7:0] RESULT;
    logic       WRITE, BUSY, DONE;
    logic [2:0] WRADDR;

    int n_cmp = 0, n_bad = 0, wr_cnt = 0;

    seq_exec_unit #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE),
        .DATA1(DATA1), .DATA2(DATA2), .DESTIN(DESTIN),
        .RESULT(RESULT), .WRITE(WRITE), .WRADDR(WRADDR), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_res(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int p;
        logic signed [7:0] s;
        logic [7:0] r;
        logic [15:0] t;
        p = $signed(a) * $signed(b);
        s = a;
        t = {a, a} >> b[2:0];
        case (op)
            2'd0: r = p[7:0];
            2'd1: r = a << b[2:0];
            2'd2: r = s >>> b[2:0];
            default: r = t[7:0];
        endcase
        return r;
    endfunction

    // Model: an accepted op at edge n finishes at edge n+L and the unit is free again two edges later.
    int n_e = 0, done_e = 0;
    bit active = 0, m_busy = 0, m_done = 0;
    logic [7:0] m_fin = 0, m_result = 0;
    logic [2:0] m_dest = 0, m_wraddr = 0;

    initial forever begin
        @(posedge CLK or negedge RESET);
        if (!RESET) begin
            active = 0; m_busy = 0; m_done = 0; m_result = 0; m_wraddr = 0;
        end else begin
            n_e++;
            if (START && (!active || n_e >= done_e + 2)) begin
                active = 1;
                done_e = n_e + ((OPCODE == 2'd0) ? 8 : int'(DATA2[2:0]));
                m_fin  = ref_res(OPCODE, DATA1, DATA2);
                m_dest = DESTIN;
            end
            m_busy = active && n_e <= done_e;
            m_done = active && n_e == done_e;
            if (m_done) begin
                m_result = m_fin;
                m_wraddr = m_dest;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        chk("busy", int'(BUSY), int'(m_busy));
        chk("done", int'(DONE), int'(m_done));
        chk("write", int'(WRITE), int'(m_done));
        chk("result", int'(RESULT), int'(m_result));
        chk("wraddr", int'(WRADDR), int'(m_wraddr));
        if (WRITE) wr_cnt++;
    end

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] d, input logic [7:0] exp, input int lat);
        int k, nb;
        k = 0; nb = 0;
        @(posedge CLK); #2;
        START = 1; OPCODE = op; DATA1 = a; DATA2 = b; DESTIN = d;
        @(posedge CLK); #2;
        START = 0;
        do begin
            @(negedge CLK);
            k++;
            nb += int'(BUSY);
        end while (!DONE && k < 20);
        chk("latency", k, lat);
        chk("busy_cycles", nb, lat);
        chk("result_lit", int'(RESULT), int'(exp));
        chk("wraddr_lit", int'(WRADDR), int'(d));
        @(posedge CLK); #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0, k, d1, d2;
        RESET = 0; START = 0; OPCODE = 0; DATA1 = 0; DATA2 = 0; DESTIN = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_write", int'(WRITE), 0);
        chk("rst_result", int'(RESULT), 0);
        chk("rst_wraddr", int'(WRADDR), 0);
        @(posedge CLK); #2;
        RESET = 1;

        run_op(2'd0, 8'h05, 8'hFD, 3'd4, 8'hF1, 9);
        run_op(2'd2, 8'h80, 8'h03, 3'd1, 8'hF0, 4);
        run_op(2'd3, 8'h81, 8'h01, 3'd3, 8'hC0, 2);
        run_op(2'd1, 8'h5A, 8'h00, 3'd7, 8'h5A, 1);
        run_op(2'd0, 8'h10, 8'h10, 3'd0, 8'h00, 9);
        run_op(2'd0, 8'hFF, 8'hFF, 3'd1, 8'h01, 9);
        run_op(2'd1, 8'h0F, 8'h07, 3'd2, 8'h80, 8);
        run_op(2'd2, 8'h7F, 8'h07, 3'd6, 8'h00, 8);
        run_op(2'd3, 8'h01, 8'h07, 3'd5, 8'h02, 8);

        // START and operand changes while running must not disturb the captured op
        w0 = wr_cnt;
        @(posedge CLK); #2;
        START = 1; OPCODE = 2'd0; DATA1 = 8'h07; DATA2 = 8'h03; DESTIN = 3'd2;
        @(posedge CLK); #2;
        START = 0;
        repeat (2) @(posedge CLK);
        #2;
        START = 1; OPCODE = 2'd1; DATA1 = 8'h55; DATA2 = 8'h00; DESTIN = 3'd7;
        @(posedge CLK); #2;
        START = 0;
        k = 0;
        do begin @(negedge CLK); k++; end while (!DONE && k < 20);
        chk("ignore_result", int'(RESULT), 8'h15);
        chk("ignore_wraddr", int'(WRADDR), 2);
        repeat (4) @(posedge CLK);
        #2;
        chk("ignore_writes", wr_cnt - w0, 1);

        // asynchronous abort in the 4th RUN cycle of a MUL
        w0 = wr_cnt;
        @(posedge CLK); #2;
        START = 1; OPCODE = 2'd0; DATA1 = 8'h09; DATA2 = 8'h07; DESTIN = 3'd5;
        @(posedge CLK); #2;
        START = 0;
        repeat (3) @(posedge CLK);
        #2;
        RESET = 0;
        #1;
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_done", int'(DONE), 0);
        chk("abort_result", int'(RESULT), 0);
        chk("abort_wraddr", int'(WRADDR), 0);
        @(posedge CLK); #2;
        RESET = 1;
        repeat (12) @(posedge CLK);
        #2;
        chk("abort_no_write", wr_cnt - w0, 0);
        run_op(2'd0, 8'h09, 8'h07, 3'd5, 8'h3F, 9);

        // START held high: completions of an L=1 op repeat every L+2 cycles
        @(posedge CLK); #2;
        START = 1; OPCODE = 2'd1; DATA1 = 8'h03; DATA2 = 8'h01; DESTIN = 3'd6;
        d1 = -100; d2 = -100;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (DONE && d1 < 0) d1 = i;
            else if (DONE && d2 < 0) d2 = i;
        end
        chk("b2b_gap", d2 - d1, 3);
        chk("b2b_result", int'(RESULT), 8'h06);
        @(posedge CLK); #2;
        START = 0;
        repeat (6) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
